// File: rtl/i2s_tx.sv
// I2S master transmitter: one-entry stereo buffer drained one pair per 2*SLOT_W-bit frame.
// Optional I2S_TX_HOLD_LAST_EN: underrun frames repeat the last latched pair instead of zeros.
module i2s_tx #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] l_data,
  input  logic [DATA_W-1:0] r_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun
);
  localparam int FRAME_W = 2 * SLOT_W;
  localparam int PAD     = SLOT_W - DATA_W;
  localparam int DIV_W   = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int P_W     = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [P_W-1:0]   P_LAST   = P_W'(FRAME_W - 1);
  localparam logic [P_W-1:0]   P_RIGHT  = P_W'(SLOT_W);

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  logic [DIV_W-1:0]   div_cnt, div_nxt;
  logic [P_W-1:0]     p_cnt, p_nxt;
  logic               started, fall, frame_start;
  logic               buf_full;
  pair_t              buf_q, src;
  logic [FRAME_W-1:0] sh_q, frame_w;
`ifdef I2S_TX_HOLD_LAST_EN
  pair_t              last_q;
`endif

  assign in_ready = !buf_full;

  // period counter idles at 0 until the first fall so that fall opens frame 0
  always_comb begin
    fall        = (div_cnt == DIV_LAST);
    div_nxt     = fall ? '0 : div_cnt + DIV_W'(1);
    frame_start = fall && (!started || p_cnt == P_LAST);
    p_nxt       = p_cnt;
    if (fall && started)
      p_nxt = (p_cnt == P_LAST) ? '0 : p_cnt + P_W'(1);
  end

  always_comb begin
`ifdef I2S_TX_HOLD_LAST_EN
    src = buf_full ? buf_q : last_q;
`else
    src = buf_full ? buf_q : '0;
`endif
    frame_w = {SLOT_W'(src.l) << PAD, SLOT_W'(src.r) << PAD};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      p_cnt   <= '0;
      started <= 1'b0;
      bclk    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      bclk    <= (div_nxt >= DIV_HALF);
      p_cnt   <= p_nxt;
      if (fall) started <= 1'b1;
    end
  end

  // sdata lags the shifter by one period, giving the I2S one-bit delay for free
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lrclk <= 1'b1;
      sdata <= 1'b0;
      sh_q  <= '0;
    end else if (fall) begin
      lrclk <= (p_nxt >= P_RIGHT);
      sdata <= sh_q[FRAME_W-1];
      sh_q  <= frame_start ? frame_w : {sh_q[FRAME_W-2:0], 1'b0};
    end
  end

  // accept needs an empty buffer, so it never collides with a drain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_full <= 1'b0;
      buf_q    <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= frame_start && !buf_full;
      if (frame_start) buf_full <= 1'b0;
      if (in_valid && !buf_full) begin
        buf_q    <= '{l: l_data, r: r_data};
        buf_full <= 1'b1;
      end
    end
  end

`ifdef I2S_TX_HOLD_LAST_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    last_q <= '0;
    else if (frame_start && buf_full) last_q <= buf_q;
  end
`endif

endmodule
